display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 151 +++++++++++++++
 tb/tb_display_scan.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// display_scan: multiplexed 8-digit seven-segment scanner.
// Time-slices eight hex digits taken from four microcontroller output
// registers onto a shared segment bus. The digit values are captured once
// per frame, so a digit never changes while the frame is being scanned.
// Blanking, leading-zero suppression and decimal points are applied live.
module display_scan #(
  parameter int unsigned DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d0_s,
  input  logic [7:0] d1_s,
  input  logic [7:0] d2_s,
  input  logic [7:0] d3_s,
  input  logic       blank,
  input  logic       lzs,
  input  logic [7:0] dp_mask,
  output logic [6:0] seg_n,
  output logic [7:0] an_n,
  output logic       dp_n,
  output logic       frame
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [2:0]  IDX_LAST = 3'd7;

  logic [15:0] cnt;
  logic        tick;
  logic        frame_end;
  logic [2:0]  idx;
  logic [31:0] snapshot;

  logic [7:0]  digit_nz;
  logic [7:0]  suppress;
  logic [3:0]  digit;
  logic        visible;
  logic [6:0]  seg_dec;

  // End of the current digit slot, and end of the whole frame.
  always_comb begin
    tick      = (cnt == DIV_LAST);
    frame_end = tick && (idx == IDX_LAST);
  end

  // Prescaler: counts clock cycles within one digit slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Digit index: advances once per slot, wraps naturally from 7 to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (tick) begin
      idx <= idx + 3'd1;
    end
  end

  // Snapshot of the port values, refreshed only at the frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snapshot <= '0;
    end else if (frame_end) begin
      snapshot <= {d3_s, d2_s, d1_s, d0_s};
    end
  end

  // Frame pulse: high for the cycle after the snapshot loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame <= 1'b0;
    end else begin
      frame <= frame_end;
    end
  end

  // Per-digit non-zero flags of the snapshot.
  always_comb begin
    digit_nz = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      digit_nz[k] = |snapshot[4*k +: 4];
    end
  end

  // Leading-zero suppression: walk from the top digit down, a digit is
  // suppressed while no non-zero digit has been seen at or above it.
  // Digit 0 always stays visible so a zero value still shows "0".
  always_comb begin
    logic seen_nz;
    seen_nz  = 1'b0;
    suppress = '0;
    for (int unsigned k = 8; k > 0; k--) begin
      seen_nz       = seen_nz | digit_nz[k-1];
      suppress[k-1] = lzs & ~seen_nz;
    end
    suppress[0] = 1'b0;
  end

  // Select the current digit and decide whether it is lit.
  always_comb begin
    digit   = snapshot[4*idx +: 4];
    visible = ~blank & ~suppress[idx];
  end

  // Hex to active-low segments {g,f,e,d,c,b,a}.
  always_comb begin
    seg_dec = 7'h7F;
    unique case (digit)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
    endcase
  end

  // Registered drive of anodes, segments and decimal point from pre-edge idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_n  <= '1;
      seg_n <= '1;
      dp_n  <= 1'b1;
    end else if (visible) begin
      an_n  <= ~(8'h01 << idx);
      seg_n <= seg_dec;
      dp_n  <= ~dp_mask[idx];
    end else begin
      an_n  <= '1;
      seg_n <= '1;
      dp_n  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: two instances (DIV=3 and DIV=1) share stimulus.
// A behavioural model predicts the post-edge outputs at every rising edge
// into per-instance queues; the falling edge pops and compares.
module tb_display_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] d0_s = '0, d1_s = '0, d2_s = '0, d3_s = '0;
  logic       blank = 1'b0;
  logic       lzs = 1'b0;
  logic [7:0] dp_mask = '0;

  logic [6:0] seg_a, seg_b;
  logic [7:0] an_a, an_b;
  logic       dp_a, dp_b, frame_a, frame_b;

  int n_vec = 0;
  int n_err = 0;

  display_scan #(.DIV(3)) u_div3 (
    .clk(clk), .reset(reset),
    .d0_s(d0_s), .d1_s(d1_s), .d2_s(d2_s), .d3_s(d3_s),
    .blank(blank), .lzs(lzs), .dp_mask(dp_mask),
    .seg_n(seg_a), .an_n(an_a), .dp_n(dp_a), .frame(frame_a)
  );

  display_scan #(.DIV(1)) u_div1 (
    .clk(clk), .reset(reset),
    .d0_s(d0_s), .d1_s(d1_s), .d2_s(d2_s), .d3_s(d3_s),
    .blank(blank), .lzs(lzs), .dp_mask(dp_mask),
    .seg_n(seg_b), .an_n(an_b), .dp_n(dp_b), .frame(frame_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          divs [2] = '{3, 1};
  int          m_cnt [2] = '{0, 0};
  int          m_idx [2] = '{0, 0};
  logic [31:0] m_snap [2] = '{32'h0, 32'h0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge of the reference for instance i.
  task automatic model_step(input int i, output exp_t e);
    logic [31:0] upper;
    logic [3:0]  dg;
    logic        vis;
    upper = m_snap[i] >> (4 * m_idx[i]);
    dg    = upper[3:0];
    vis   = !blank && !(lzs && m_idx[i] != 0 && upper == 32'h0);
    if (vis) begin
      e.an  = ~(8'h01 << m_idx[i]);
      e.seg = seg_lut[dg];
      e.dp  = ~dp_mask[m_idx[i]];
    end else begin
      e.an  = 8'hFF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end
    e.fr = (m_cnt[i] == divs[i] - 1) && (m_idx[i] == 7);
    if (m_cnt[i] == divs[i] - 1) begin
      m_cnt[i] = 0;
      if (m_idx[i] == 7) m_snap[i] = {d3_s, d2_s, d1_s, d0_s};
      m_idx[i] = (m_idx[i] + 1) % 8;
    end else begin
      m_cnt[i] = m_cnt[i] + 1;
    end
  endtask

  // Reference model: predicts on rising clock, resets asynchronously.
  initial begin
    exp_t e0, e1, er;
    er.an = 8'hFF; er.seg = 7'h7F; er.dp = 1'b1; er.fr = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < 2; i++) begin
          m_cnt[i] = 0; m_idx[i] = 0; m_snap[i] = '0;
        end
        if (clk) begin
          q0.push_back(er);
          q1.push_back(er);
        end
      end else begin
        model_step(0, e0);
        model_step(1, e1);
        q0.push_back(e0);
        q1.push_back(e1);
      end
    end
  end

  // Checker: compare on falling edge; also probe outputs shortly after an
  // asynchronous reset assertion that happens between edges.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("an_div3", 32'(an_a), 32'(e.an));
        check("seg_div3", 32'(seg_a), 32'(e.seg));
        check("dp_div3", 32'(dp_a), 32'(e.dp));
        check("frame_div3", 32'(frame_a), 32'(e.fr));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("an_div1", 32'(an_b), 32'(e.an));
        check("seg_div1", 32'(seg_b), 32'(e.seg));
        check("dp_div1", 32'(dp_b), 32'(e.dp));
        check("frame_div1", 32'(frame_b), 32'(e.fr));
      end
      #2;
      if (reset) begin
        check("rst_an_div3", 32'(an_a), 32'hFF);
        check("rst_seg_div3", 32'(seg_a), 32'h7F);
        check("rst_dp_div3", 32'(dp_a), 32'h1);
        check("rst_frame_div3", 32'(frame_a), 32'h0);
        check("rst_an_div1", 32'(an_b), 32'hFF);
        check("rst_seg_div1", 32'(seg_b), 32'h7F);
        check("rst_dp_div1", 32'(dp_b), 32'h1);
        check("rst_frame_div1", 32'(frame_b), 32'h0);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_digits(input logic [31:0] v);
    {d3_s, d2_s, d1_s, d0_s} = v;
  endtask

  // Reset pulse raised and dropped between edges (inside the low phase).
  task automatic pulse_reset(input int low_cycles);
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (low_cycles) @(negedge clk);
    #3 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    // Held in reset, then release: d0=21, no suppression.
    set_digits(32'h0000_0021);
    run(3);
    #3 reset = 1'b0;
    run(80);

    // Only digit 0 non-zero with suppression on.
    set_digits(32'h0000_0005);
    lzs = 1'b1;
    run(60);

    // All zero with suppression: digit 0 still shows "0".
    set_digits(32'h0);
    run(60);

    // Mid-frame change of d2_s, suppression off.
    lzs = 1'b0;
    set_digits(32'h00AA_0000);
    run(30);
    d2_s = 8'hFF;
    run(60);

    // Blank for 20 cycles, scanning continues.
    set_digits(32'h1234_5678);
    blank = 1'b1;
    run(20);
    blank = 1'b0;
    run(30);

    // Decimal point on digit 4, then all points.
    dp_mask = 8'h10;
    run(50);
    dp_mask = 8'hFF;
    run(30);
    dp_mask = 8'h00;

    // Top digit only / every digit F with suppression.
    lzs = 1'b1;
    set_digits(32'hF000_0000);
    run(30);
    set_digits(32'hFFFF_FFFF);
    run(30);

    // Random mixes of digits, suppression, blanking and points.
    for (int k = 0; k < 12; k++) begin
      r = $urandom;
      set_digits(r >> $urandom_range(0, 31));
      lzs     = 1'($urandom_range(0, 1));
      blank   = ($urandom_range(0, 5) == 0);
      dp_mask = 8'($urandom);
      run($urandom_range(5, 40));
    end
    blank = 1'b0;

    // Asynchronous reset mid-frame, then check restart timing.
    lzs = 1'b0;
    set_digits(32'h8765_4321);
    run(17);
    pulse_reset(0);
    run(60);
    pulse_reset(2);
    run(40);

    run(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
